cpu_ctrl_seq: RTL and testbench
===============================

# cpu_ctrl_seq

Multi-cycle control sequencer for the 16-bit CPU core. Fetches each instruction over a request/acknowledge instruction-memory port, decodes it, and drives the datapath controls for one instruction at a time: the two immediate-select lines of the ALU operand-B mux, ALU op, register-file addresses and write enable, data-memory handshake and PC. Sits between the memories and the existing datapath (register file, immediate generator, operand-B mux, ALU).

## Interface
- No parameters; data width fixed at 16, register index 3 bits.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  16  instruction word
- pc  out  16  word address of current instruction (imem address)
- imm_ctrl_6  out  1  operand B = sign-extended imm6
- imm_ctrl_3  out  1  operand B = zero-extended imm3
- imm_field  out  6  ir[5:0] to immediate generator
- alu_op  out  3  ALU function code
- alu_zero  in  1  ALU result == 0
- rs1_addr, rs2_addr, rd_addr  out  3 each  register-file addresses
- rf_we  out  1  register write strobe
- wb_sel_mem  out  1  write-back source: 1 = dmem_rdata, 0 = ALU
- dmem_req, dmem_we  out  1 each  data-memory request / write
- dmem_ack  in  1  data-memory access complete
- halted  out  1  core stopped (HALT or illegal opcode)

## Operation
- Opcode ir[15:12]; rd ir[11:9], rs1 ir[8:6], rs2 ir[5:3], imm6 ir[5:0], imm3 ir[2:0].
- 0x0–0x7 R-type: alu_op = opcode[2:0], register operands, write rd.
- 0x8 ADDI (alu_op 0, imm_ctrl_6); 0x9 SLLI (alu_op 5, imm_ctrl_3); 0xA SRLI (alu_op 6, imm_ctrl_3).
- 0xB LW: rd ← mem[rs1+imm6]. 0xC SW: mem[rs1+imm6] ← r[ir[11:9]] (rs2_addr = ir[11:9]).
- 0xD BEQ: alu_op 1 (SUB) of rs1, r[ir[11:9]]; taken if alu_zero; target pc+1+sext(imm6).
- 0xE illegal, 0xF HALT: both → HALT state.
- States: FETCH → DECODE → EXEC → {WB | MEM | FETCH}; MEM → WB (LW) or FETCH (SW); WB → FETCH; HALT sticky until reset.
- FETCH: imem_req=1 until imem_ack; on ack latch ir. DECODE: register all controls. EXEC: ALU operands stable, BEQ resolved. MEM: dmem_req=1 (dmem_we for SW) held until dmem_ack. WB: rf_we=1 exactly one cycle.
- imm_ctrl_6 and imm_ctrl_3 never both 1; both 0 for R-type and BEQ; held constant DECODE through end of instruction.
- rf_we suppressed when rd_addr == 0 (r0 reads zero).
- PC: updated on leaving the instruction's last state; +1 mod 2^16 (0xFFFF → 0x0000); branch target modulo 2^16.

## Timing
- Reset (async): state FETCH, pc 0, ir 0, all outputs 0, halted 0. imem_req asserts first cycle after rst_n deasserts.
- Zero-wait memories: ack may assert in the same cycle as req; R-type/ADDI/shifts 4 cycles, BEQ/SW 3/4 cycles (SW: FETCH, DECODE, EXEC, MEM), LW 5.
- Each wait cycle on imem_ack/dmem_ack adds one cycle; req held, outputs frozen.
- ack while corresponding req low: ignored.
- Reset asserted mid-MEM/FETCH: req drops immediately; no write-back occurs.
- In HALT: all req/we low, pc frozen at HALT/illegal instruction address, halted=1.

## Configuration
- CPU_CTRL_PERF_EN defined: adds outputs cycle_cnt[31:0] (increments every non-reset, non-HALT cycle) and instret_cnt[31:0] (increments on each instruction retire, excl. HALT/illegal); both wrap, reset to 0.
- Undefined: counters and ports absent; behaviour otherwise identical.

## Structure
- Shared package cpu_pkg: state enum, opcode constants, alu_op codes, field bit positions.
- One sub-module ctrl_decode: combinational ir → {imm_ctrl_6, imm_ctrl_3, alu_op, addresses, class flags}; sequencer registers its outputs in DECODE.

## Test plan
- Reset, imem returns 0x8241 (ADDI r1,r1,1) zero-wait → imm_ctrl_6=1 from DECODE, rf_we single pulse cycle 4, rd_addr 1, pc=1 after.
- 0x9283 (SLLI r1,r2,3) → imm_ctrl_3=1, imm_ctrl_6=0, alu_op 5.
- LW with dmem_ack delayed 3 cycles → dmem_req held 4 cycles, wb_sel_mem=1, instruction takes 8 cycles.
- BEQ at pc 0x0005, imm6 0x3E, alu_zero=1 → next pc 0x0004; alu_zero=0 → 0x0006; BEQ at 0xFFFF not taken → 0x0000.
- Write to r0 (0x0000 R-type) → rf_we stays 0; opcode 0xE → halted=1, pc frozen, no further imem_req.
- rst_n low during MEM with dmem_req high → dmem_req 0 immediately, pc 0, restart from FETCH.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the cpu_ctrl_seq control sequencer: FSM states,
// opcodes, ALU codes, instruction field positions and decoded controls.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_SLLI = 4'h9;
  localparam logic [3:0] OP_SRLI = 4'hA;
  localparam logic [3:0] OP_LW   = 4'hB;
  localparam logic [3:0] OP_SW   = 4'hC;
  localparam logic [3:0] OP_BEQ  = 4'hD;
  localparam logic [3:0] OP_ILL  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;

  typedef struct packed {
    logic       imm6;
    logic       imm3;
    logic [2:0] alu_op;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic       we;
    logic       load;
    logic       store;
    logic       branch;
    logic       halt;
  } ctrl_t;

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

endpackage

// File: rtl/cpu_ctrl_seq_if.sv
// Memory-side bus of the sequencer: imem fetch handshake + pc,
// dmem request/write/ack. master = sequencer, slave = memories.
interface cpu_ctrl_seq_if;

  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] pc;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req, pc, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, pc, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: instr -> ctrl_t
// (imm selects, alu_op, rs1/rs2/rd, class flags).
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [15:0] instr,
  output ctrl_t       ctrl
);

  logic [3:0] op;

  assign op = instr[OP_HI:OP_LO];

  always_comb begin
    ctrl     = '0;
    ctrl.rs1 = instr[RS1_HI:RS1_LO];
    ctrl.rs2 = instr[RS2_HI:RS2_LO];
    ctrl.rd  = instr[RD_HI:RD_LO];
    unique case (1'b1)
      (op[3] == 1'b0): begin
        ctrl.alu_op = op[2:0];
        ctrl.we     = 1'b1;
      end
      (op == OP_ADDI): begin
        ctrl.imm6   = 1'b1;
        ctrl.alu_op = ALU_ADD;
        ctrl.we     = 1'b1;
      end
      (op == OP_SLLI): begin
        ctrl.imm3   = 1'b1;
        ctrl.alu_op = ALU_SLL;
        ctrl.we     = 1'b1;
      end
      (op == OP_SRLI): begin
        ctrl.imm3   = 1'b1;
        ctrl.alu_op = ALU_SRL;
        ctrl.we     = 1'b1;
      end
      (op == OP_LW): begin
        ctrl.imm6   = 1'b1;
        ctrl.alu_op = ALU_ADD;
        ctrl.we     = 1'b1;
        ctrl.load   = 1'b1;
      end
      (op == OP_SW): begin
        ctrl.imm6   = 1'b1;
        ctrl.alu_op = ALU_ADD;
        ctrl.store  = 1'b1;
        ctrl.rs2    = instr[RD_HI:RD_LO];
        ctrl.rd     = 3'd0;
      end
      (op == OP_BEQ): begin
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
        ctrl.rs2    = instr[RD_HI:RD_LO];
        ctrl.rd     = 3'd0;
      end
      (op == OP_ILL), (op == OP_HALT): begin
        ctrl.halt = 1'b1;
      end
      default: begin
        ctrl.halt = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Ports: clk, rst_n, mem (cpu_ctrl_seq_if.master: imem/dmem
// handshakes, pc), datapath controls imm_ctrl_6/imm_ctrl_3,
// imm_field, alu_op, alu_zero, rs1/rs2/rd_addr, rf_we, wb_sel_mem,
// halted. Macro CPU_CTRL_PERF_EN adds cycle_cnt/instret_cnt.
module cpu_ctrl_seq
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  cpu_ctrl_seq_if.master    mem,
  output logic              imm_ctrl_6,
  output logic              imm_ctrl_3,
  output logic [5:0]        imm_field,
  output logic [2:0]        alu_op,
  input  logic              alu_zero,
  output logic [2:0]        rs1_addr,
  output logic [2:0]        rs2_addr,
  output logic [2:0]        rd_addr,
  output logic              rf_we,
  output logic              wb_sel_mem,
  output logic              halted
`ifdef CPU_CTRL_PERF_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt
`endif
);

  state_e      state_q;
  state_e      state_d;
  ctrl_t       ctrl_q;
  ctrl_t       dec;
  logic [5:0]  imm_q;
  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic        retire;
  logic        latch;

  ctrl_decode u_dec (
    .instr (mem.imem_rdata),
    .ctrl  (dec)
  );

  // Controls are captured with the instruction word so they are
  // already stable during DECODE and stay put to the end.
  assign latch = (state_q == S_FETCH) && mem.imem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (latch) begin
        ctrl_q <= dec;
        imm_q  <= mem.imem_rdata[5:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (mem.imem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = ctrl_q.halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (ctrl_q.branch) begin
          state_d = S_FETCH;
          retire  = 1'b1;
          pc_d    = alu_zero ?
                    pc_q + 16'd1 + sext6(imm_q) :
                    pc_q + 16'd1;
        end else if (ctrl_q.load || ctrl_q.store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem.dmem_ack) begin
          if (ctrl_q.load) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
            pc_d    = pc_q + 16'd1;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
        pc_d    = pc_q + 16'd1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // rst_n gate keeps the fetch request low while reset is held.
  assign mem.imem_req = rst_n && (state_q == S_FETCH);
  assign mem.dmem_req = (state_q == S_MEM);
  assign mem.dmem_we  = (state_q == S_MEM) && ctrl_q.store;
  assign mem.pc       = pc_q;

  assign rf_we      = (state_q == S_WB) && ctrl_q.we &&
                      (ctrl_q.rd != 3'd0);
  assign halted     = (state_q == S_HALT);
  assign imm_ctrl_6 = ctrl_q.imm6;
  assign imm_ctrl_3 = ctrl_q.imm3;
  assign imm_field  = imm_q;
  assign alu_op     = ctrl_q.alu_op;
  assign rs1_addr   = ctrl_q.rs1;
  assign rs2_addr   = ctrl_q.rs2;
  assign rd_addr    = ctrl_q.rd;
  assign wb_sel_mem = ctrl_q.load;

`ifdef CPU_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed self-checking bench for cpu_ctrl_seq.
// Drives imem/dmem acks and alu_zero; checks controls and pc.
module tb_cpu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alu_zero = 1'b0;
  logic       imm_ctrl_6, imm_ctrl_3;
  logic [5:0] imm_field;
  logic [2:0] alu_op, rs1_addr, rs2_addr, rd_addr;
  logic       rf_we, wb_sel_mem, halted;
`ifdef CPU_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cpu_ctrl_seq_if bus ();

  cpu_ctrl_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (bus),
    .imm_ctrl_6 (imm_ctrl_6),
    .imm_ctrl_3 (imm_ctrl_3),
    .imm_field  (imm_field),
    .alu_op     (alu_op),
    .alu_zero   (alu_zero),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd_addr    (rd_addr),
    .rf_we      (rf_we),
    .wb_sel_mem (wb_sel_mem),
    .halted     (halted)
`ifdef CPU_CTRL_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    alu_zero = 1'b0;
    step;
    step;
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for a fetch request, then returns the word
  // zero-wait; leaves the DUT in DECODE.
  task automatic fetch(input logic [15:0] w);
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      step;
      n++;
    end
    checks++;
    if (bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_timeout: imem_req=%b want 1", bus.imem_req);
    end
    bus.imem_rdata = w;
    bus.imem_ack = 1'b1;
    step;
    bus.imem_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b0;
    bus.imem_rdata = 16'hF000;
    step;
    step;
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_imem_req: got %b want 0", bus.imem_req);
    end
    checks++;
    if (bus.pc !== 16'h0000) begin
      errors++;
      $display("FAIL rst_pc: got %h want 0000", bus.pc);
    end
    checks++;
    if ({halted, rf_we, bus.dmem_req, imm_ctrl_6, imm_ctrl_3}
        !== 5'b0) begin
      errors++;
      $display("FAIL rst_outs: got %b want 00000",
               {halted, rf_we, bus.dmem_req, imm_ctrl_6, imm_ctrl_3});
    end
    checks++;
    if (alu_op !== 3'd0) begin
      errors++;
      $display("FAIL rst_alu_op: got %0d want 0", alu_op);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_first_req: got %b want 1", bus.imem_req);
    end
  endtask

  task automatic test_addi;
    fetch(16'h8241);
    checks++;
    if ({imm_ctrl_6, imm_ctrl_3} !== 2'b10) begin
      errors++;
      $display("FAIL addi_imm: got %b want 10", {imm_ctrl_6, imm_ctrl_3});
    end
    checks++;
    if ({alu_op, rd_addr, rs1_addr} !== {3'd0, 3'd1, 3'd1}) begin
      errors++;
      $display("FAIL addi_fields: got %h/%h/%h want 0/1/1",
               alu_op, rd_addr, rs1_addr);
    end
    checks++;
    if (imm_field !== 6'h01) begin
      errors++;
      $display("FAIL addi_imm_field: got %h want 01", imm_field);
    end
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL addi_we_decode: got %b want 0", rf_we);
    end
    step;
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL addi_we_exec: got %b want 0", rf_we);
    end
    step;
    checks++;
    if (rf_we !== 1'b1 || wb_sel_mem !== 1'b0) begin
      errors++;
      $display("FAIL addi_we_wb: got %b/%b want 1/0", rf_we, wb_sel_mem);
    end
    step;
    checks++;
    if (rf_we !== 1'b0 || bus.pc !== 16'h0001) begin
      errors++;
      $display("FAIL addi_after: we=%b pc=%h want 0/0001", rf_we, bus.pc);
    end
    checks++;
    if (bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL addi_refetch: got %b want 1", bus.imem_req);
    end
`ifdef CPU_CTRL_PERF_EN
    checks++;
    if (cycle_cnt !== 32'd4 || instret_cnt !== 32'd1) begin
      errors++;
      $display("FAIL perf_addi: got %0d/%0d want 4/1",
               cycle_cnt, instret_cnt);
    end
`endif
  endtask

  task automatic test_slli;
    fetch(16'h9283);
    checks++;
    if ({imm_ctrl_6, imm_ctrl_3} !== 2'b01) begin
      errors++;
      $display("FAIL slli_imm: got %b want 01", {imm_ctrl_6, imm_ctrl_3});
    end
    checks++;
    if ({alu_op, rd_addr, rs1_addr} !== {3'd5, 3'd1, 3'd2}) begin
      errors++;
      $display("FAIL slli_fields: got %h/%h/%h want 5/1/2",
               alu_op, rd_addr, rs1_addr);
    end
    step;
    step;
    step;
    checks++;
    if (bus.pc !== 16'h0002) begin
      errors++;
      $display("FAIL slli_pc: got %h want 0002", bus.pc);
    end
  endtask

  task automatic test_lw_wait;
    int req_n = 0;
    bus.dmem_ack = 1'b0;
    fetch(16'hB642);
    checks++;
    if ({wb_sel_mem, imm_ctrl_6, rd_addr, rs1_addr}
        !== {1'b1, 1'b1, 3'd3, 3'd1}) begin
      errors++;
      $display("FAIL lw_decode: got %b/%b/%h/%h want 1/1/3/1",
               wb_sel_mem, imm_ctrl_6, rd_addr, rs1_addr);
    end
    step;
    checks++;
    if (bus.dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL lw_exec_req: got %b want 0", bus.dmem_req);
    end
    step;
    checks++;
    if (bus.dmem_we !== 1'b0) begin
      errors++;
      $display("FAIL lw_we: got %b want 0", bus.dmem_we);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.dmem_req === 1'b1) req_n++;
      if (i == 3) bus.dmem_ack = 1'b1;
      step;
    end
    bus.dmem_ack = 1'b0;
    checks++;
    if (req_n !== 4) begin
      errors++;
      $display("FAIL lw_req_cycles: got %0d want 4", req_n);
    end
    checks++;
    if (rf_we !== 1'b1 || bus.dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL lw_wb: we=%b req=%b want 1/0", rf_we, bus.dmem_req);
    end
    step;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.pc !== 16'h0003) begin
      errors++;
      $display("FAIL lw_len: req=%b pc=%h want 1/0003",
               bus.imem_req, bus.pc);
    end
  endtask

  task automatic test_sw;
    bus.dmem_ack = 1'b1;
    fetch(16'hC445);
    checks++;
    if ({rs2_addr, rs1_addr, imm_ctrl_6} !== {3'd2, 3'd1, 1'b1}) begin
      errors++;
      $display("FAIL sw_decode: got %h/%h/%b want 2/1/1",
               rs2_addr, rs1_addr, imm_ctrl_6);
    end
    step;
    checks++;
    if (bus.dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL sw_exec_req: got %b want 0", bus.dmem_req);
    end
    step;
    checks++;
    if ({bus.dmem_req, bus.dmem_we, rf_we} !== 3'b110) begin
      errors++;
      $display("FAIL sw_mem: got %b want 110",
               {bus.dmem_req, bus.dmem_we, rf_we});
    end
    step;
    bus.dmem_ack = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.pc !== 16'h0004) begin
      errors++;
      $display("FAIL sw_len: req=%b pc=%h want 1/0004",
               bus.imem_req, bus.pc);
    end
  endtask

  task automatic test_rtype;
    int we_n = 0;
    fetch(16'h74E0);
    checks++;
    if ({alu_op, rs1_addr, rs2_addr, rd_addr}
        !== {3'd7, 3'd3, 3'd4, 3'd2}) begin
      errors++;
      $display("FAIL rtype_fields: got %h/%h/%h/%h want 7/3/4/2",
               alu_op, rs1_addr, rs2_addr, rd_addr);
    end
    checks++;
    if ({imm_ctrl_6, imm_ctrl_3, wb_sel_mem} !== 3'b000) begin
      errors++;
      $display("FAIL rtype_imm: got %b want 000",
               {imm_ctrl_6, imm_ctrl_3, wb_sel_mem});
    end
    step;
    step;
    step;
    checks++;
    if (bus.pc !== 16'h0005) begin
      errors++;
      $display("FAIL rtype_pc: got %h want 0005", bus.pc);
    end
    fetch(16'h0000);
    for (int i = 0; i < 3; i++) begin
      if (rf_we !== 1'b0) we_n++;
      step;
    end
    checks++;
    if (we_n !== 0 || rd_addr !== 3'd0) begin
      errors++;
      $display("FAIL r0_we: got %0d pulses rd=%h want 0/0", we_n, rd_addr);
    end
    checks++;
    if (bus.pc !== 16'h0006) begin
      errors++;
      $display("FAIL r0_pc: got %h want 0006", bus.pc);
    end
  endtask

  task automatic test_branch;
    do_reset;
    alu_zero = 1'b1;
    fetch(16'hD284);
    checks++;
    if ({alu_op, rs1_addr, rs2_addr, imm_ctrl_6, imm_ctrl_3}
        !== {3'd1, 3'd2, 3'd1, 2'b00}) begin
      errors++;
      $display("FAIL beq_decode: got %h/%h/%h/%b want 1/2/1/00",
               alu_op, rs1_addr, rs2_addr, {imm_ctrl_6, imm_ctrl_3});
    end
    step;
    step;
    checks++;
    if (bus.pc !== 16'h0005 || bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL beq_fwd: pc=%h req=%b want 0005/1",
               bus.pc, bus.imem_req);
    end
    fetch(16'hD2BE);
    step;
    step;
    checks++;
    if (bus.pc !== 16'h0004) begin
      errors++;
      $display("FAIL beq_back: got %h want 0004", bus.pc);
    end
    fetch(16'h8241);
    step;
    step;
    step;
    alu_zero = 1'b0;
    fetch(16'hD2BE);
    step;
    step;
    checks++;
    if (bus.pc !== 16'h0006) begin
      errors++;
      $display("FAIL beq_not_taken: got %h want 0006", bus.pc);
    end
    do_reset;
    alu_zero = 1'b1;
    fetch(16'hD2BE);
    step;
    step;
    checks++;
    if (bus.pc !== 16'hFFFF) begin
      errors++;
      $display("FAIL beq_wrap_target: got %h want ffff", bus.pc);
    end
    alu_zero = 1'b0;
    fetch(16'hD2BE);
    step;
    step;
    checks++;
    if (bus.pc !== 16'h0000) begin
      errors++;
      $display("FAIL beq_pc_wrap: got %h want 0000", bus.pc);
    end
  endtask

  task automatic test_halt;
    int act_n = 0;
`ifdef CPU_CTRL_PERF_EN
    logic [31:0] cyc;
`endif
    do_reset;
    fetch(16'h8241);
    step;
    step;
    step;
    fetch(16'hE000);
    step;
    checks++;
    if (halted !== 1'b1 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL ill_halt: halted=%b req=%b want 1/0",
               halted, bus.imem_req);
    end
`ifdef CPU_CTRL_PERF_EN
    cyc = cycle_cnt;
`endif
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.imem_req || bus.dmem_req || bus.dmem_we || rf_we) act_n++;
      step;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    checks++;
    if (act_n !== 0 || halted !== 1'b1 || bus.pc !== 16'h0001) begin
      errors++;
      $display("FAIL ill_sticky: act=%0d halted=%b pc=%h want 0/1/0001",
               act_n, halted, bus.pc);
    end
`ifdef CPU_CTRL_PERF_EN
    checks++;
    if (cycle_cnt !== cyc || instret_cnt !== 32'd1) begin
      errors++;
      $display("FAIL perf_halt: got %0d/%0d want %0d/1",
               cycle_cnt, instret_cnt, cyc);
    end
`endif
    do_reset;
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_clear: got %b want 0", halted);
    end
    fetch(16'hF000);
    step;
    checks++;
    if (halted !== 1'b1 || bus.pc !== 16'h0000) begin
      errors++;
      $display("FAIL halt_op: halted=%b pc=%h want 1/0000",
               halted, bus.pc);
    end
  endtask

  task automatic test_reset_mid_mem;
    do_reset;
    fetch(16'h8241);
    step;
    step;
    step;
    bus.dmem_ack = 1'b0;
    fetch(16'hB642);
    step;
    step;
    checks++;
    if (bus.dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_mem_req: got %b want 1", bus.dmem_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.dmem_req, bus.imem_req, rf_we} !== 3'b000) begin
      errors++;
      $display("FAIL mid_rst_outs: got %b want 000",
               {bus.dmem_req, bus.imem_req, rf_we});
    end
    checks++;
    if (bus.pc !== 16'h0000) begin
      errors++;
      $display("FAIL mid_rst_pc: got %h want 0000", bus.pc);
    end
    step;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart: got %b want 1", bus.imem_req);
    end
    fetch(16'h8241);
    step;
    step;
    step;
    checks++;
    if (bus.pc !== 16'h0001) begin
      errors++;
      $display("FAIL mid_after: got %h want 0001", bus.pc);
    end
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 16'h0000;
    bus.dmem_ack = 1'b0;
    test_reset;
    test_addi;
    test_slli;
    test_lw_wait;
    test_sw;
    test_rtype;
    test_branch;
    test_halt;
    test_reset_mid_mem;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
